unidade_controle_param: RTL

- Parametrised successor of the ultimate tic-tac-toe control FSM.
- Internalises the settle, validation and end-hold wait counters, which were previously external fimS/fimT timers.
- Owns the current-player register and adds a per-turn move timeout. On timeout the turn passes and the next player gets a free macro choice.
- Sits between the button/edge datapath and the board RAMs.

---
 rtl/jogo_pkg.sv | 49 ++++
 rtl/contador_espera.sv | 25 ++
 rtl/unidade_controle_param.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// Shared state codes and default timing for the parametrised tic-tac-toe controller.
package jogo_pkg;

  localparam logic [3:0] ST_INICIAL            = 4'h0;
  localparam logic [3:0] ST_PREPARACAO         = 4'h1;
  localparam logic [3:0] ST_JOGA_MACRO         = 4'h2;
  localparam logic [3:0] ST_REGISTRA_MACRO     = 4'h3;
  localparam logic [3:0] ST_VALIDA_MACRO       = 4'h4;
  localparam logic [3:0] ST_JOGA_MICRO         = 4'h5;
  localparam logic [3:0] ST_REGISTRA_MICRO     = 4'h6;
  localparam logic [3:0] ST_VALIDA_MICRO       = 4'h7;
  localparam logic [3:0] ST_REGISTRA_JOGADA    = 4'h8;
  localparam logic [3:0] ST_VERIFICA_MACRO     = 4'h9;
  localparam logic [3:0] ST_REGISTRA_RESULTADO = 4'hA;
  localparam logic [3:0] ST_VERIFICA_TABULEIRO = 4'hB;
  localparam logic [3:0] ST_TROCAR_JOGADOR     = 4'hC;
  localparam logic [3:0] ST_DECIDE_MACRO       = 4'hD;
  localparam logic [3:0] ST_ESTOURO_TEMPO      = 4'hE;
  localparam logic [3:0] ST_FIM                = 4'hF;

  typedef enum logic [3:0] {
    INICIAL            = ST_INICIAL,
    PREPARACAO         = ST_PREPARACAO,
    JOGA_MACRO         = ST_JOGA_MACRO,
    REGISTRA_MACRO     = ST_REGISTRA_MACRO,
    VALIDA_MACRO       = ST_VALIDA_MACRO,
    JOGA_MICRO         = ST_JOGA_MICRO,
    REGISTRA_MICRO     = ST_REGISTRA_MICRO,
    VALIDA_MICRO       = ST_VALIDA_MICRO,
    REGISTRA_JOGADA    = ST_REGISTRA_JOGADA,
    VERIFICA_MACRO     = ST_VERIFICA_MACRO,
    REGISTRA_RESULTADO = ST_REGISTRA_RESULTADO,
    VERIFICA_TABULEIRO = ST_VERIFICA_TABULEIRO,
    TROCAR_JOGADOR     = ST_TROCAR_JOGADOR,
    DECIDE_MACRO       = ST_DECIDE_MACRO,
    ESTOURO_TEMPO      = ST_ESTOURO_TEMPO,
    FIM                = ST_FIM
  } estado_t;

  localparam int SETTLE_CYC_DEF       = 4;
  localparam int VALID_CYC_DEF        = 3;
  localparam int END_HOLD_CYC_DEF     = 5;
  localparam int MOVE_TIMEOUT_CYC_DEF = 20;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/contador_espera.sv
// Clear/enable up-counter that stops at a terminal value and flags it.
module contador_espera #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] term,
  output logic             fim
);

  logic [WIDTH-1:0] cnt;

  // Stopping at term (rather than wrapping) keeps waits that also need an input satisfied.
  always_ff @(posedge clock) begin
    if (reset || clear)
      cnt <= '0;
    else if (enable && !fim)
      cnt <= cnt + WIDTH'(1);
  end

  assign fim = (cnt == term);

endmodule

// File: rtl/unidade_controle_param.sv
// Tic-tac-toe control FSM with internal settle/validate/hold waits, player register and move timeout.
// State codes and meanings live in jogo_pkg; db_estado exposes the code directly.
module unidade_controle_param
  import jogo_pkg::*;
#(
  parameter int   SETTLE_CYC       = SETTLE_CYC_DEF,
  parameter int   VALID_CYC        = VALID_CYC_DEF,
  parameter int   END_HOLD_CYC     = END_HOLD_CYC_DEF,
  parameter int   MOVE_TIMEOUT_CYC = MOVE_TIMEOUT_CYC_DEF,
  parameter logic JOGADOR_INICIAL  = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       fim_jogo,
  input  logic       macro_vencida,
  input  logic       micro_jogada,
  output logic       sinal_macro,
  output logic       sinal_valida_macro,
  output logic       zeraR_macro,
  output logic       zeraR_micro,
  output logic       zeraEdge,
  output logic       zeraRAM,
  output logic       registraR_macro,
  output logic       registraR_micro,
  output logic       we_board,
  output logic       we_board_state,
  output logic       troca_jogador,
  output logic       jogar_macro,
  output logic       jogar_micro,
  output logic       pronto,
  output logic       jogador,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int WAIT_MAX = max_int(max_int(SETTLE_CYC, VALID_CYC), END_HOLD_CYC);
  localparam int WW = $clog2(max_int(WAIT_MAX, 2)) + 1;
  localparam int MW = $clog2(max_int(MOVE_TIMEOUT_CYC, 2)) + 1;
  localparam logic [MW-1:0] MOVE_TERM = MW'(MOVE_TIMEOUT_CYC > 0 ? MOVE_TIMEOUT_CYC - 1 : 0);

  estado_t       estado, prox;
  logic [WW-1:0] w_term;
  logic          w_fim, m_fim, m_en, m_clear, estouro, livre;
  logic          we_board_q, we_state_q;

  always_comb begin
    w_term = '0;
    case (estado)
      JOGA_MACRO, JOGA_MICRO, REGISTRA_JOGADA,
      REGISTRA_RESULTADO, TROCAR_JOGADOR: w_term = WW'(SETTLE_CYC - 1);
      VALIDA_MACRO, VALIDA_MICRO:         w_term = WW'(VALID_CYC - 1);
      FIM:                                w_term = WW'(END_HOLD_CYC - 1);
      default:                            w_term = '0;
    endcase
  end

  assign m_en    = (estado == JOGA_MACRO) || (estado == JOGA_MICRO);
  assign m_clear = (estado == INICIAL) || (estado == TROCAR_JOGADOR);
  assign estouro = (MOVE_TIMEOUT_CYC > 0) && m_en && m_fim;

  contador_espera #(.WIDTH(WW)) u_wcnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (prox != estado),
    .enable (1'b1),
    .term   (w_term),
    .fim    (w_fim)
  );

  contador_espera #(.WIDTH(MW)) u_mcnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (m_clear),
    .enable (m_en),
    .term   (MOVE_TERM),
    .fim    (m_fim)
  );

  // A completed move takes priority over a timeout expiring on the same cycle.
  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:            if (iniciar) prox = PREPARACAO;
      PREPARACAO:         prox = JOGA_MACRO;
      JOGA_MACRO:         if (w_fim && tem_jogada) prox = REGISTRA_MACRO;
                          else if (estouro) prox = ESTOURO_TEMPO;
      REGISTRA_MACRO:     prox = VALIDA_MACRO;
      VALIDA_MACRO:       if (w_fim) prox = macro_vencida ? PREPARACAO : JOGA_MICRO;
      JOGA_MICRO:         if (w_fim && tem_jogada) prox = REGISTRA_MICRO;
                          else if (estouro) prox = ESTOURO_TEMPO;
      REGISTRA_MICRO:     prox = VALIDA_MICRO;
      VALIDA_MICRO:       if (w_fim) prox = micro_jogada ? JOGA_MICRO : REGISTRA_JOGADA;
      REGISTRA_JOGADA:    if (w_fim) prox = VERIFICA_MACRO;
      VERIFICA_MACRO:     prox = REGISTRA_RESULTADO;
      REGISTRA_RESULTADO: if (w_fim) prox = VERIFICA_TABULEIRO;
      VERIFICA_TABULEIRO: prox = fim_jogo ? FIM : TROCAR_JOGADOR;
      TROCAR_JOGADOR:     if (w_fim) prox = livre ? PREPARACAO : DECIDE_MACRO;
      DECIDE_MACRO:       prox = macro_vencida ? PREPARACAO : JOGA_MICRO;
      ESTOURO_TEMPO:      prox = TROCAR_JOGADOR;
      FIM:                if (w_fim && iniciar) prox = INICIAL;
      default:            prox = INICIAL;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado             <= INICIAL;
      livre              <= 1'b0;
      jogador            <= JOGADOR_INICIAL;
      zeraR_macro        <= 1'b1;
      zeraR_micro        <= 1'b1;
      zeraEdge           <= 1'b1;
      zeraRAM            <= 1'b1;
      registraR_macro    <= 1'b0;
      registraR_micro    <= 1'b0;
      sinal_macro        <= 1'b0;
      sinal_valida_macro <= 1'b0;
      jogar_macro        <= 1'b0;
      jogar_micro        <= 1'b0;
      we_board_q         <= 1'b0;
      we_state_q         <= 1'b0;
      troca_jogador      <= 1'b0;
      pronto             <= 1'b0;
      timeout            <= 1'b0;
      db_estado          <= ST_INICIAL;
    end else begin
      estado <= prox;
      if (estado == PREPARACAO)
        livre <= 1'b0;
      else if (estado == ESTOURO_TEMPO)
        livre <= 1'b1;
      if (estado == TROCAR_JOGADOR && prox != TROCAR_JOGADOR)
        jogador <= ~jogador;
      zeraR_macro        <= (prox == INICIAL) || (prox == PREPARACAO);
      zeraR_micro        <= (prox == INICIAL) || (prox == PREPARACAO) || (prox == JOGA_MICRO);
      zeraEdge           <= (prox == INICIAL);
      zeraRAM            <= (prox == INICIAL);
      registraR_macro    <= (prox == REGISTRA_MACRO) || (prox == DECIDE_MACRO);
      registraR_micro    <= (prox == REGISTRA_MICRO);
      sinal_macro        <= (prox == JOGA_MACRO) || (prox == REGISTRA_MACRO);
      sinal_valida_macro <= (prox == REGISTRA_MACRO) || (prox == VALIDA_MACRO) ||
                            (prox == REGISTRA_RESULTADO);
      jogar_macro        <= (prox == JOGA_MACRO);
      jogar_micro        <= (prox == JOGA_MICRO);
      we_board_q         <= (prox == REGISTRA_JOGADA);
      we_state_q         <= (prox == REGISTRA_RESULTADO);
      troca_jogador      <= (prox == TROCAR_JOGADOR);
      pronto             <= (prox == FIM);
      timeout            <= (prox == ESTOURO_TEMPO);
      db_estado          <= prox;
    end
  end

  // Board writes are blocked during the cycle reset is asserted.
  assign we_board       = we_board_q & ~reset;
  assign we_board_state = we_state_q & ~reset;

endmodule
